// File: rtl/fpu_pack_fmac_if.sv
// Purpose : bundles the handshake, result and flag signals of the FMAC pack stage.
// Latency : n/a (wiring only).
// Backpr. : n/a; carries Valid/Ready on the input side and Valid/Ready on the output side.
//
// Signals (slave = the pack stage itself, master = its upstream/downstream environment):
//   input side : Valid_SI, Ready_SO, Mant_res_DI, Exp_res_DI, Sign_res_DI, Exp_OF_SI,
//                Exp_UF_SI, Flag_Inexact_SI, Invalid_SI, Inf_op_SI, RM_SI, Tag_DI
//   output side: Valid_SO, Ready_SI, Result_DO, Flags_DO, Tag_DO
//   CSR side   : Fflags_DO, Fflags_clr_SI
interface fpu_pack_fmac_if #(
    parameter int C_EXP  = 8,
    parameter int C_MANT = 23,
    parameter int C_RM   = 3,
    parameter int C_TAG  = 4
);
    logic                      Valid_SI;
    logic                      Ready_SO;
    logic [C_MANT-1:0]         Mant_res_DI;
    logic [C_EXP-1:0]          Exp_res_DI;
    logic                      Sign_res_DI;
    logic                      Exp_OF_SI;
    logic                      Exp_UF_SI;
    logic                      Flag_Inexact_SI;
    logic                      Invalid_SI;
    logic                      Inf_op_SI;
    logic [C_RM-1:0]           RM_SI;
    logic [C_TAG-1:0]          Tag_DI;

    logic                      Valid_SO;
    logic                      Ready_SI;
    logic [C_EXP+C_MANT:0]     Result_DO;
    logic [4:0]                Flags_DO;
    logic [C_TAG-1:0]          Tag_DO;

    logic [4:0]                Fflags_DO;
    logic                      Fflags_clr_SI;

    modport slave (
        input  Valid_SI, Mant_res_DI, Exp_res_DI, Sign_res_DI, Exp_OF_SI, Exp_UF_SI,
               Flag_Inexact_SI, Invalid_SI, Inf_op_SI, RM_SI, Tag_DI,
               Ready_SI, Fflags_clr_SI,
        output Ready_SO, Valid_SO, Result_DO, Flags_DO, Tag_DO, Fflags_DO
    );

    modport master (
        output Valid_SI, Mant_res_DI, Exp_res_DI, Sign_res_DI, Exp_OF_SI, Exp_UF_SI,
               Flag_Inexact_SI, Invalid_SI, Inf_op_SI, RM_SI, Tag_DI,
               Ready_SI, Fflags_clr_SI,
        input  Ready_SO, Valid_SO, Result_DO, Flags_DO, Tag_DO, Fflags_DO
    );
endinterface

// File: rtl/fpu_pack_fmac.sv
// Purpose : packs the rounded FMAC result into binary32, applies overflow rules per rounding
//           mode, computes {NV,DZ,OF,UF,NX}, queues results and accumulates sticky fflags.
// Latency : 1 cycle from input handshake to head of an empty queue.
// Backpr. : 2-entry queue; Ready_SO = occupancy<2 from registered state only, no path from Ready_SI.
//
// Ports:
//   Clk_CI  clock, Rst_RI synchronous active-high reset
//   io      fpu_pack_fmac_if.slave: input result + handshake, output head entry + handshake,
//           sticky Fflags_DO with its clear Fflags_clr_SI
module fpu_pack_fmac #(
    parameter int C_EXP  = 8,
    parameter int C_MANT = 23,
    parameter int C_RM   = 3,
    parameter int C_TAG  = 4
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,
    fpu_pack_fmac_if.slave       io
);

    localparam int C_W = C_EXP + C_MANT + 1;

    localparam logic [C_RM-1:0] RM_RTZ = C_RM'(1);
    localparam logic [C_RM-1:0] RM_RDN = C_RM'(2);
    localparam logic [C_RM-1:0] RM_RUP = C_RM'(3);

    typedef struct packed {
        logic [C_W-1:0]   word;
        logic [4:0]       flags;
        logic [C_TAG-1:0] tag;
    } entry_t;

    // ------------------------------------------------------------------
    // Packing and flag generation (before enqueue)
    // ------------------------------------------------------------------
    logic   flag_nv;
    logic   flag_of;
    logic   flag_uf;
    logic   flag_nx;
    logic   sat_max;
    entry_t in_ent;

    always_comb begin
        flag_nv = io.Invalid_SI;
        // An infinite operand produces an exact infinity, not an overflow.
        flag_of = io.Exp_OF_SI & ~io.Inf_op_SI & ~io.Invalid_SI;
        flag_nx = (io.Flag_Inexact_SI | flag_of) & ~io.Invalid_SI;
        // Tininess only counts as underflow when the result is also inexact.
        flag_uf = io.Exp_UF_SI & flag_nx;

        // Directed roundings that point toward zero saturate to the largest finite
        // value; encodings 4..7 fall through to the round-to-nearest behaviour.
        sat_max = 1'b0;
        case (io.RM_SI)
            RM_RTZ:  sat_max = 1'b1;
            RM_RDN:  sat_max = ~io.Sign_res_DI;
            RM_RUP:  sat_max = io.Sign_res_DI;
            default: sat_max = 1'b0;
        endcase

        in_ent.tag   = io.Tag_DI;
        in_ent.flags = {flag_nv, 1'b0, flag_of, flag_uf, flag_nx};

        if (io.Invalid_SI) begin
            // Canonical quiet NaN.
            in_ent.word = {1'b0, {C_EXP{1'b1}}, 1'b1, {(C_MANT-1){1'b0}}};
        end else if (flag_of && sat_max) begin
            in_ent.word = {io.Sign_res_DI, {(C_EXP-1){1'b1}}, 1'b0, {C_MANT{1'b1}}};
        end else if (io.Exp_OF_SI) begin
            // Rounded-up overflow and infinite-operand results are both signed infinity.
            in_ent.word = {io.Sign_res_DI, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
        end else begin
            in_ent.word = {io.Sign_res_DI, io.Exp_res_DI, io.Mant_res_DI};
        end
    end

    // ------------------------------------------------------------------
    // 2-entry queue: slot0 is always the head, slot1 the second entry.
    // ------------------------------------------------------------------
    entry_t     slot0;
    entry_t     slot1;
    logic [1:0] occ;
    logic       push;
    logic       pop;

    assign io.Ready_SO = (occ != 2'd2);
    assign io.Valid_SO = (occ != 2'd0);
    assign push        = io.Valid_SI & io.Ready_SO;
    assign pop         = io.Valid_SO & io.Ready_SI;

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            slot0 <= '0;
            slot1 <= '0;
            occ   <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        slot0 <= in_ent;
                    end else begin
                        slot1 <= in_ent;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                // Push with pop only happens at occupancy 1 (full queue blocks push):
                // the new entry replaces the departing head.
                2'b11: slot0 <= in_ent;
                default: ;
            endcase
        end
    end

    assign io.Result_DO = slot0.word;
    assign io.Flags_DO  = slot0.flags;
    assign io.Tag_DO    = slot0.tag;

    // ------------------------------------------------------------------
    // Sticky fflags: clear takes effect before the popped entry's flags are ORed in.
    // ------------------------------------------------------------------
    logic [4:0] fflags_q;

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            fflags_q <= 5'd0;
        end else if (pop) begin
            fflags_q <= (io.Fflags_clr_SI ? 5'd0 : fflags_q) | slot0.flags;
        end else if (io.Fflags_clr_SI) begin
            fflags_q <= 5'd0;
        end
    end

    assign io.Fflags_DO = fflags_q;

endmodule

// File: doc/fpu_pack_fmac.md
Name: fpu_pack_fmac

Overview:
- Output stage directly downstream of the FMAC normalization/rounding stage.
- Takes the rounded sign/exponent/mantissa plus overflow, underflow and inexact indications, and applies IEEE overflow-result rules per rounding mode.
- Packs a binary32 word and computes the 5-bit exception flags.
- Buffers results in a 2-entry valid/ready queue and keeps a sticky accumulated fflags register for the CSR.

Parameters:
- C_EXP, 8, exponent width.
- C_MANT, 23, stored mantissa width.
- C_RM, 3, rounding-mode width (RNE=0, RTZ=1, RDN=2, RUP=3).
- C_TAG, 4, width of the opaque tag carried with each result.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  synchronous active-high reset.
- Valid_SI  in  1  input result valid.
- Ready_SO  out  1  stage can accept.
- Mant_res_DI  in  C_MANT  rounded mantissa.
- Exp_res_DI  in  C_EXP  rounded exponent.
- Sign_res_DI  in  1  result sign.
- Exp_OF_SI  in  1  overflow/infinite result indication.
- Exp_UF_SI  in  1  tiny (denormal/zero-exponent) result.
- Flag_Inexact_SI  in  1  rounding discarded bits.
- Invalid_SI  in  1  invalid operation (NaN source, 0*Inf, Inf-Inf).
- Inf_op_SI  in  1  an operand was infinite.
- RM_SI  in  C_RM  rounding mode of this operation.
- Tag_DI  in  C_TAG  tag.
- Valid_SO  out  1  output valid.
- Ready_SI  in  1  consumer ready.
- Result_DO  out  C_EXP+C_MANT+1  packed result.
- Flags_DO  out  5  {NV,DZ,OF,UF,NX} of head entry.
- Tag_DO  out  C_TAG  head tag.
- Fflags_DO  out  5  accumulated sticky flags.
- Fflags_clr_SI  in  1  clear accumulated flags.

Behaviour:
- Reset: entries invalidated, Valid_SO=0, Ready_SO=1, Result_DO=0, Flags_DO=0, Tag_DO=0, Fflags_DO=0. Reset mid-operation drops all entries.
- Input handshake: fires on Valid_SI & Ready_SO. Ready_SO = (occupancy<2), registered-state only; no combinational path from Ready_SI.
- Output handshake: fires on Valid_SO & Ready_SI. Valid_SO = (occupancy>0).
- Latency: accepted result is visible on outputs the next cycle when the queue was empty.
- Ordering: FIFO. Outputs are the head entry and hold stable while Valid_SO=1 and Ready_SI=0.
- Full queue (occupancy 2): a simultaneous pop accepts nothing that cycle, because Ready_SO is already 0.
- Empty queue: a push occupies the head; occupancy becomes 1.
- Push and pop in the same cycle with occupancy 1: occupancy stays 1 and the new entry becomes head.
- Packing, computed before enqueue and stored in the entry:
  - NV = Invalid_SI.
  - DZ = 0.
  - OF = Exp_OF_SI & ~Inf_op_SI & ~Invalid_SI.
  - NX = (Flag_Inexact_SI | OF) & ~Invalid_SI.
  - UF = Exp_UF_SI & NX.
  - Invalid_SI: word = 0x7FC00000, all other flags 0.
  - OF with RM = RTZ, or RDN with sign 0, or RUP with sign 1: word = {sign, 0xFE, all-ones mantissa}, i.e. largest finite.
  - Otherwise OF: word = {sign, 0xFF, 0}.
  - Else: word = {Sign_res_DI, Exp_res_DI, Mant_res_DI}.
  - RM values 4..7 are treated as RNE.
- Fflags accumulation: on each output handshake, Fflags |= Flags_DO.
  - Fflags_clr_SI in the same cycle: Fflags = Flags_DO of the popped entry, i.e. clear first, then OR.
  - Clear without a pop: Fflags = 0 the next cycle.

Test Plan:
- Normal pack: sign 0, exp 0x80, mant 0x400000, all flags 0, Ready_SI=1 -> next cycle Result_DO=0x40400000, Flags_DO=0, Valid_SO=1 for exactly 1 cycle.
- Overflow by rounding mode: Exp_OF_SI=1, Inf_op_SI=0, sign 0. RM=RTZ -> 0x7F7FFFFF, flags OF|NX=0x05. RM=RUP -> 0x7F800000, same flags. Sign 1 with RDN -> 0xFF800000.
- Invalid vs infinite operand: Invalid_SI=1 -> 0x7FC00000, flags 0x10. Exp_OF_SI=1 with Inf_op_SI=1, sign 1 -> 0xFF800000, flags 0.
- Underflow: Exp_UF_SI=1, Inexact=1, exp 0, mant 0x000001 -> 0x00000001, flags UF|NX=0x03. Same with Inexact=0 -> flags 0.
- Backpressure: Ready_SI=0, push 3 back-to-back -> Ready_SO drops after 2 accepted, third held. Release Ready_SI -> tags out in order A,B, then C accepted; no loss or duplication.
- Fflags: pop NX entry, then UF|NX entry -> Fflags=0x03. Clear asserted together with a pop of an OF|NX entry -> Fflags=0x05. Clear alone -> 0. Reset during full queue -> Valid_SO=0, Fflags=0 next cycle.
